memory_sdp_be: RTL and testbench
================================

// Module: memory_sdp_be
// PURPOSE
//   Simple-dual-port synchronous RAM: one write port with byte enables, one
//   registered read port with valid flag, configurable read-during-write
//   behaviour, and a hardware clear engine that zeroes the array after reset
//   or on request. Next-generation storage for HD vectors/accumulators,
//   supporting concurrent read and write in one cycle.
// PARAMETERS
//   DATA_WIDTH     32              word width in bits; multiple of 8
//   ADDR_WIDTH     8               address width in bits
//   RAM_DEPTH      1<<ADDR_WIDTH   number of words; <= 2**ADDR_WIDTH
//   RDW_MODE       0               same-address read during write: 0=old data, 1=new data
//   CLEAR_ON_RESET 1               1: run clear sweep after reset release; 0: no sweep
// PORTS
//   clk        in   1               clock; all state updates on posedge
//   rst        in   1               asynchronous, active-high reset
//   clear_req  in   1               start clear sweep (sampled in IDLE only)
//   busy       out  1               1 while clear sweep runs
//   wr_en      in   1               write strobe
//   wr_addr    in   ADDR_WIDTH      write address
//   wr_data    in   DATA_WIDTH      write data
//   wr_be      in   DATA_WIDTH/8    byte enables; bit i writes wr_data[8i+7:8i]
//   rd_en      in   1               read strobe
//   rd_addr    in   ADDR_WIDTH      read address
//   rd_data    out  DATA_WIDTH      registered read data
//   rd_valid   out  1               rd_data updated by a read in the previous cycle
// BEHAVIOUR
//   - Reset (async assert): rd_data=0, rd_valid=0, clear counter=0; state=CLEAR
//     if CLEAR_ON_RESET else IDLE; busy=1 iff state=CLEAR. Array contents not
//     reset directly.
//   - FSM: IDLE --clear_req--> CLEAR; CLEAR --counter==RAM_DEPTH-1--> IDLE.
//     In CLEAR: one word per cycle, mem[counter]<=0, counter++; sweep takes
//     exactly RAM_DEPTH cycles; busy drops the cycle after the last word.
//   - While busy: wr_en and rd_en ignored (no write, rd_valid=0, rd_data holds).
//     clear_req while busy ignored (no restart). Reset mid-sweep restarts at 0.
//   - Write (IDLE, wr_en=1, wr_addr<RAM_DEPTH): per enabled byte lane, mem
//     updated at posedge; disabled lanes keep contents. wr_be=0 is a no-op.
//   - Read (IDLE, rd_en=1): latency 1. rd_data<=mem[rd_addr], rd_valid<=1 at
//     the same edge; rd_en=0 -> rd_valid<=0, rd_data holds last value.
//   - Out-of-range (addr>=RAM_DEPTH): write dropped; read returns 0, rd_valid=1.
//   - Same-address read+write same cycle: RDW_MODE=0 -> pre-write word;
//     RDW_MODE=1 -> merged word (enabled lanes from wr_data, others old).
//   - Read and write to different addresses in one cycle fully independent.
//   - Back-to-back reads: one result per cycle, no bubbles.
// TESTING
//   1. Reset, CLEAR_ON_RESET=1, DEPTH=256: busy=1 for 256 cycles then 0; read
//      every address -> 0x00000000, rd_valid=1 one cycle after each rd_en.
//   2. Write 0xDEADBEEF @0x10 be=4'hF, then 0x11223344 be=4'b0101 -> read @0x10
//      returns 0xDE22BE44.
//   3. Mem[0x20]=0xAAAAAAAA; same cycle wr 0x55555555 be=4'hF + rd @0x20:
//      RDW_MODE=0 -> 0xAAAAAAAA; RDW_MODE=1 -> 0x55555555; next read 0x55555555.
//   4. clear_req with data present; wr_en/rd_en asserted during sweep -> no
//      writes, rd_valid stays 0; after busy falls all words read 0.
//   5. Assert rst at sweep counter=100 -> sweep restarts at 0, busy held for
//      a full RAM_DEPTH cycles after release.
//   6. RAM_DEPTH=200, ADDR_WIDTH=8: write @250 dropped; read @250 -> 0, rd_valid=1;
//      streaming reads @0..199 yield one rd_valid per cycle.

Source files
------------

// File: rtl/memory_sdp_be.sv
// Simple-dual-port RAM with byte-enable writes, registered read with valid flag,
// selectable read-during-write behaviour and a one-word-per-cycle clear engine.
module memory_sdp_be #(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned ADDR_WIDTH     = 8,
    parameter int unsigned RAM_DEPTH      = 1 << ADDR_WIDTH,
    parameter bit          RDW_MODE       = 1'b0,
    parameter bit          CLEAR_ON_RESET = 1'b1
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    clear_req_i,
    output logic                    busy_o,
    input  logic                    wr_en_i,
    input  logic [ADDR_WIDTH-1:0]   wr_addr_i,
    input  logic [DATA_WIDTH-1:0]   wr_data_i,
    input  logic [DATA_WIDTH/8-1:0] wr_be_i,
    input  logic                    rd_en_i,
    input  logic [ADDR_WIDTH-1:0]   rd_addr_i,
    output logic [DATA_WIDTH-1:0]   rd_data_o,
    output logic                    rd_valid_o
);

    localparam int unsigned NumBytes = DATA_WIDTH / 8;

    typedef enum logic [0:0] {StIdle, StClear} state_e;

    state_e                state_q;
    logic [ADDR_WIDTH-1:0] cnt_q;
    logic [DATA_WIDTH-1:0] rd_data_q;
    logic                  rd_valid_q;
    logic [DATA_WIDTH-1:0] mem [RAM_DEPTH];

    logic                  idle;
    logic                  wr_ok;
    logic                  rd_ok;
    logic                  rd_in_range;
    logic                  cnt_last;
    logic [DATA_WIDTH-1:0] rd_word;
    logic [DATA_WIDTH-1:0] rd_d;

    assign idle        = (state_q == StIdle);
    assign wr_ok       = idle && wr_en_i && (32'(wr_addr_i) < RAM_DEPTH);
    assign rd_ok       = idle && rd_en_i;
    assign rd_in_range = (32'(rd_addr_i) < RAM_DEPTH);
    assign cnt_last    = (cnt_q == ADDR_WIDTH'(RAM_DEPTH - 1));

    // Out-of-range reads return zero; new-data mode forwards the enabled write lanes.
    always_comb begin
        rd_word = '0;
        if (rd_in_range) begin
            rd_word = mem[rd_addr_i];
        end
        rd_d = rd_word;
        if (RDW_MODE && wr_ok && (wr_addr_i == rd_addr_i)) begin
            for (int i = 0; i < NumBytes; i++) begin
                if (wr_be_i[i]) begin
                    rd_d[8*i +: 8] = wr_data_i[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            if (!idle) begin
                mem[cnt_q] <= '0;
            end else if (wr_ok) begin
                for (int i = 0; i < NumBytes; i++) begin
                    if (wr_be_i[i]) begin
                        mem[wr_addr_i][8*i +: 8] <= wr_data_i[8*i +: 8];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= CLEAR_ON_RESET ? StClear : StIdle;
            cnt_q      <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (clear_req_i) begin
                        state_q <= StClear;
                        cnt_q   <= '0;
                    end
                end
                StClear: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_last) begin
                        state_q <= StIdle;
                        cnt_q   <= '0;
                    end
                end
                default: state_q <= StIdle;
            endcase
            rd_valid_q <= rd_ok;
            if (rd_ok) begin
                rd_data_q <= rd_d;
            end
        end
    end

    assign busy_o     = (state_q == StClear);
    assign rd_data_o  = rd_data_q;
    assign rd_valid_o = rd_valid_q;

endmodule

// File: tb/tb_memory_sdp_be.sv
// Bench for memory_sdp_be: an old-data 256-word instance and a new-data 200-word instance
// share stimulus; a per-instance model and queue predict every read result.
module tb_memory_sdp_be;

    logic        clk;
    logic        rst;
    logic        clear_req;
    logic        wr_en;
    logic [7:0]  wr_addr;
    logic [31:0] wr_data;
    logic [3:0]  wr_be;
    logic        rd_en;
    logic [7:0]  rd_addr;
    logic        busy0, busy1;
    logic [31:0] rd_data0, rd_data1;
    logic        rd_valid0, rd_valid1;

    int unsigned n_total = 0;
    int unsigned n_pass  = 0;
    int unsigned bc0, bc1;
    bit          tb_idle;
    logic        vexp;
    logic [31:0] last0, last1;
    logic [31:0] m0 [256];
    logic [31:0] m1 [256];
    logic [31:0] q0 [$];
    logic [31:0] q1 [$];

    memory_sdp_be #(
        .DATA_WIDTH(32), .ADDR_WIDTH(8), .RAM_DEPTH(256), .RDW_MODE(1'b0), .CLEAR_ON_RESET(1'b1)
    ) u_dut0 (
        .clk_i(clk), .rst_i(rst), .clear_req_i(clear_req), .busy_o(busy0),
        .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data), .wr_be_i(wr_be),
        .rd_en_i(rd_en), .rd_addr_i(rd_addr), .rd_data_o(rd_data0), .rd_valid_o(rd_valid0)
    );

    memory_sdp_be #(
        .DATA_WIDTH(32), .ADDR_WIDTH(8), .RAM_DEPTH(200), .RDW_MODE(1'b1), .CLEAR_ON_RESET(1'b1)
    ) u_dut1 (
        .clk_i(clk), .rst_i(rst), .clear_req_i(clear_req), .busy_o(busy1),
        .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data), .wr_be_i(wr_be),
        .rd_en_i(rd_en), .rd_addr_i(rd_addr), .rd_data_o(rd_data1), .rd_valid_o(rd_valid1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h, want %h", tag, obs, exp);
    endtask

    function automatic logic [31:0] model_rd(input int k, input bit wen, input int wa,
                                             input logic [31:0] wd, input logic [3:0] be,
                                             input int ra);
        int          depth;
        logic [31:0] v;
        depth = (k == 1) ? 200 : 256;
        if (ra >= depth) return 32'h0;
        v = (k == 1) ? m1[ra] : m0[ra];
        if (k == 1 && wen && wa == ra) begin
            for (int b = 0; b < 4; b++) if (be[b]) v[8*b +: 8] = wd[8*b +: 8];
        end
        return v;
    endfunction

    function automatic int pick_addr();
        int r;
        r = int'($urandom_range(0, 19));
        if (r < 16) return r;
        if (r == 16) return 199;
        if (r == 17) return 200;
        if (r == 18) return 250;
        return 255;
    endfunction

    // Inputs change just after a posedge; the next posedge captures them.
    task automatic drive(input bit wen, input int wa, input logic [31:0] wd, input logic [3:0] be,
                         input bit ren, input int ra, input bit creq);
        wr_en     = wen;
        wr_addr   = 8'(wa);
        wr_data   = wd;
        wr_be     = be;
        rd_en     = ren;
        rd_addr   = 8'(ra);
        clear_req = creq;
        if (ren && tb_idle) begin
            q0.push_back(model_rd(0, wen, wa, wd, be, ra));
            q1.push_back(model_rd(1, wen, wa, wd, be, ra));
        end
        if (wen && tb_idle) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b] && wa < 256) m0[wa][8*b +: 8] = wd[8*b +: 8];
                if (be[b] && wa < 200) m1[wa][8*b +: 8] = wd[8*b +: 8];
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic nop();
        drive(1'b0, 0, 32'h0, 4'h0, 1'b0, 0, 1'b0);
    endtask

    task automatic zero_models();
        for (int i = 0; i < 256; i++) begin
            m0[i] = 32'h0;
            m1[i] = 32'h0;
        end
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) vexp <= 1'b0;
        else     vexp <= rd_en & tb_idle;
    end

    always @(negedge clk) begin
        if (rst) begin
            last0 = 32'h0;
            last1 = 32'h0;
        end else begin
            if (busy0) bc0++;
            if (busy1) bc1++;
            check("valid0", 32'(rd_valid0), 32'(vexp));
            check("valid1", 32'(rd_valid1), 32'(vexp));
            if (rd_valid0) begin
                if (q0.size() > 0) begin
                    last0 = q0.pop_front();
                    check("rd0", rd_data0, last0);
                end
            end else begin
                check("hold0", rd_data0, last0);
            end
            if (rd_valid1) begin
                if (q1.size() > 0) begin
                    last1 = q1.pop_front();
                    check("rd1", rd_data1, last1);
                end
            end else begin
                check("hold1", rd_data1, last1);
            end
        end
    end

    initial begin
        rst = 1'b1; tb_idle = 1'b0;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0; wr_be = '0;
        rd_en = 1'b0; rd_addr = '0; clear_req = 1'b0;
        bc0 = 0; bc1 = 0;
        zero_models();
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy0", 32'(busy0), 32'd1);
        check("rst_busy1", 32'(busy1), 32'd1);
        check("rst_valid0", 32'(rd_valid0), 32'd0);
        check("rst_data0", rd_data0, 32'h0);
        check("rst_data1", rd_data1, 32'h0);

        // Power-up sweep length, then every address reads zero back-to-back.
        rst = 1'b0; bc0 = 0; bc1 = 0;
        repeat (300) nop();
        check("sweep0_len", bc0, 32'd256);
        check("sweep1_len", bc1, 32'd200);
        tb_idle = 1'b1;
        for (int a = 0; a < 256; a++) drive(1'b0, 0, 32'h0, 4'h0, 1'b1, a, 1'b0);
        nop();

        // Byte-lane merge.
        drive(1'b1, 'h10, 32'hDEADBEEF, 4'hF, 1'b0, 0, 1'b0);
        drive(1'b1, 'h10, 32'h11223344, 4'b0101, 1'b0, 0, 1'b0);
        drive(1'b0, 0, 32'h0, 4'h0, 1'b1, 'h10, 1'b0);

        // Same-address read during write, full and partial lanes.
        drive(1'b1, 'h20, 32'hAAAAAAAA, 4'hF, 1'b0, 0, 1'b0);
        drive(1'b1, 'h20, 32'h55555555, 4'hF, 1'b1, 'h20, 1'b0);
        drive(1'b0, 0, 32'h0, 4'h0, 1'b1, 'h20, 1'b0);
        drive(1'b1, 'h21, 32'h01020304, 4'hF, 1'b0, 0, 1'b0);
        drive(1'b1, 'h21, 32'hA0B0C0D0, 4'b1010, 1'b1, 'h21, 1'b0);
        drive(1'b0, 0, 32'h0, 4'h0, 1'b1, 'h21, 1'b0);
        drive(1'b1, 'h22, 32'hFFFFFFFF, 4'h0, 1'b1, 'h22, 1'b0);

        // Range edge for the 200-word instance.
        drive(1'b1, 250, 32'hCAFEF00D, 4'hF, 1'b0, 0, 1'b0);
        drive(1'b1, 199, 32'h12345678, 4'hF, 1'b1, 250, 1'b0);
        drive(1'b0, 0, 32'h0, 4'h0, 1'b1, 199, 1'b0);

        // Mixed random traffic, including concurrent different-address accesses.
        for (int i = 0; i < 300; i++) begin
            drive(1'($urandom_range(0, 1)), pick_addr(), $urandom, 4'($urandom_range(0, 15)),
                  1'($urandom_range(0, 1)), pick_addr(), 1'b0);
        end
        nop();

        // Requested clear with traffic and a second clear_req during the sweep.
        drive(1'b0, 0, 32'h0, 4'h0, 1'b0, 0, 1'b1);
        tb_idle = 1'b0; bc0 = 0; bc1 = 0;
        for (int i = 0; i < 300; i++) begin
            drive(i < 150, int'($urandom_range(0, 63)), 32'hA5A5A5A5, 4'hF, i < 150,
                  int'($urandom_range(0, 63)), i == 50);
        end
        check("clr0_len", bc0, 32'd256);
        check("clr1_len", bc1, 32'd200);
        zero_models();
        tb_idle = 1'b1;
        for (int a = 0; a < 64; a++) drive(1'b0, 0, 32'h0, 4'h0, 1'b1, a, 1'b0);
        drive(1'b0, 0, 32'h0, 4'h0, 1'b1, 199, 1'b0);
        drive(1'b0, 0, 32'h0, 4'h0, 1'b1, 250, 1'b0);

        // Reset in the middle of a sweep restarts it from word 0.
        for (int a = 0; a < 8; a++) drive(1'b1, a, 32'h5A000000 + 32'(a), 4'hF, 1'b0, 0, 1'b0);
        nop();
        tb_idle = 1'b0;
        rst = 1'b1;
        nop();
        rst = 1'b0;
        repeat (100) nop();
        rst = 1'b1;
        #1;
        check("mid_rst_busy0", 32'(busy0), 32'd1);
        check("mid_rst_valid1", 32'(rd_valid1), 32'd0);
        nop();
        rst = 1'b0; bc0 = 0; bc1 = 0;
        repeat (300) nop();
        check("restart0_len", bc0, 32'd256);
        check("restart1_len", bc1, 32'd200);
        zero_models();
        tb_idle = 1'b1;
        for (int a = 0; a < 16; a++) drive(1'b0, 0, 32'h0, 4'h0, 1'b1, a, 1'b0);
        repeat (2) nop();

        check("drain0", q0.size(), 32'd0);
        check("drain1", q1.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
